// File: rtl/cov_stall_watchdog_if.sv
// Handshake bundle between the coverage-stall watchdog and its host.
// Signal prefixes are from the watchdog's point of view.
interface cov_stall_watchdog_if #(
   parameter int NCH   = 2,
   parameter int COV_W = 30
);
   logic                 i_enable;
   logic [NCH*COV_W-1:0] i_cov;
   logic [63:0]          i_tohost;
   logic                 i_irq_ack;
   logic                 o_interrupt;
   logic [1:0]           o_cause;
   logic [NCH-1:0]       o_stall_mask;
   logic [15:0]          o_fire_count;

   modport master (
      output i_enable, i_cov, i_tohost, i_irq_ack,
      input  o_interrupt, o_cause, o_stall_mask, o_fire_count
   );

   modport slave (
      input  i_enable, i_cov, i_tohost, i_irq_ack,
      output o_interrupt, o_cause, o_stall_mask, o_fire_count
   );
endinterface

// File: rtl/cov_stall_watchdog.sv
// Coverage-stall watchdog: interrupts when coverage sums stop moving for a
// coverage-scaled number of cycles, or when no pass is reported for too long.
module cov_stall_watchdog #(
   parameter int NCH         = 2,
   parameter int COV_W       = 30,
   parameter int BASE_WAIT   = 1000,
   parameter int SCALE_SHIFT = 19,
   parameter int WDOG_LIMIT  = 50000,
   parameter int HOLDOFF     = 16,
   parameter int STALL_MODE  = 0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   cov_stall_watchdog_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FIRED = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam int              HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLDOFF - 1);
   localparam logic [31:0]     SAT32     = 32'hFFFF_FFFF;

   logic [1:0]     r_state;
   logic [1:0]     w_state_next;
   logic [31:0]    r_wdog;
   logic [HW-1:0]  r_hold;
   logic           r_irq;
   logic [1:0]     r_cause;
   logic [NCH-1:0] r_mask;
   logic [15:0]    r_fire_cnt;

   logic [NCH-1:0] w_stall;
   logic           w_host;
   logic           w_clr;
   logic           w_run;
   logic           w_stall_cond;
   logic           w_wdog_cond;
   logic           w_fire;
   logic           w_unused_tohost;

   // A pass report only matters once armed; enable low outranks it.
   assign w_host          = bus.i_enable && bus.i_tohost[0] && (r_state != S_IDLE);
   assign w_clr           = !bus.i_enable || w_host || (r_state == S_IDLE) || (r_state == S_HOLD);
   assign w_run           = !w_clr && (r_state == S_RUN);
   assign w_wdog_cond     = (r_wdog >= 32'(WDOG_LIMIT));
   assign w_unused_tohost = ^bus.i_tohost[63:1];

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         logic [COV_W-1:0] r_pre_cov;
         logic [31:0]      r_cnt;
         logic [COV_W-1:0] w_cov_ch;
         logic [63:0]      w_prod;
         logic [31:0]      w_thr;
         logic             w_changed;

         assign w_cov_ch  = bus.i_cov[gi*COV_W +: COV_W];
         assign w_prod    = 64'(BASE_WAIT) * (64'(w_cov_ch >> SCALE_SHIFT) + 64'd1);
         assign w_thr     = (w_prod > 64'(SAT32)) ? SAT32 : w_prod[31:0];
         assign w_changed = (w_cov_ch != r_pre_cov);
         // A change on the same edge as a threshold hit wins: no stall.
         assign w_stall[gi] = !w_changed && (r_cnt >= w_thr);

         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_pre_cov <= '0;
               r_cnt     <= '0;
            end else if (w_clr) begin
               r_cnt <= '0;
            end else if (w_run) begin
               if (w_changed) begin
                  r_pre_cov <= w_cov_ch;
                  r_cnt     <= '0;
               end else if (r_cnt != SAT32) begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
         end
      end

      if (STALL_MODE == 0) begin : g_all
         assign w_stall_cond = &w_stall;
      end else begin : g_any
         assign w_stall_cond = |w_stall;
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_fire       = 1'b0;
      if (!bus.i_enable) begin
         w_state_next = S_IDLE;
      end else if (w_host) begin
         w_state_next = S_RUN;
      end else begin
         case (r_state)
            S_IDLE:  w_state_next = S_RUN;
            S_RUN: begin
               if (w_stall_cond || w_wdog_cond) begin
                  w_state_next = S_FIRED;
                  w_fire       = 1'b1;
               end
            end
            S_FIRED: begin
               if (bus.i_irq_ack) w_state_next = S_HOLD;
            end
            S_HOLD: begin
               if (r_hold == HOLD_LAST) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_wdog     <= '0;
         r_hold     <= '0;
         r_irq      <= 1'b0;
         r_cause    <= 2'b00;
         r_mask     <= '0;
         r_fire_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_irq   <= (w_state_next == S_FIRED);
         r_mask  <= w_stall;

         if (w_clr) begin
            r_wdog <= '0;
         end else if (w_run && (r_wdog != SAT32)) begin
            r_wdog <= r_wdog + 32'd1;
         end

         // Hold counter restarts every time HOLD is entered.
         if ((r_state == S_HOLD) && (w_state_next == S_HOLD)) begin
            r_hold <= r_hold + HW'(1);
         end else begin
            r_hold <= '0;
         end

         if (w_host) begin
            r_cause <= 2'b00;
         end else if (w_fire) begin
            r_cause <= {w_wdog_cond, w_stall_cond};
         end

         if (w_fire && (r_fire_cnt != 16'hFFFF)) begin
            r_fire_cnt <= r_fire_cnt + 16'd1;
         end
      end
   end

   assign bus.o_interrupt  = r_irq;
   assign bus.o_cause      = r_cause;
   assign bus.o_stall_mask = r_mask;
   assign bus.o_fire_count = r_fire_cnt;
endmodule
